// File: rtl/fixed_point_iterative_fft_pkg.sv
// Shared types for the iterative radix-2 FFT control path: sequencer states and
// the butterfly multiplier shortcut codes understood by the datapath.
package fixed_point_iterative_fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    localparam logic [2:0] MULT_GENERAL   = 3'd0;
    localparam logic [2:0] MULT_W_ONE     = 3'd1;
    localparam logic [2:0] MULT_W_NEG_ONE = 3'd2;
    localparam logic [2:0] MULT_W_POS_J   = 3'd3;
    localparam logic [2:0] MULT_W_NEG_J   = 3'd4;

endpackage

// File: rtl/fixed_point_iterative_fft_agu.sv
// Combinational address generator: maps (stage, butterfly index) to the two
// in-place sample addresses, the twiddle index and the multiplier shortcut code.
module fixed_point_iterative_fft_agu
    import fixed_point_iterative_fft_pkg::*;
#(
    parameter int N = 8,
    localparam int LOG2N = $clog2(N),
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic [SW-1:0]    stage_i,
    input  logic [LOG2N-2:0] bidx_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_o,
    output logic [2:0]       mult_o
);

    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [LOG2N-2:0] TW_NEG_J   = (LOG2N - 1)'(N / 4);

    logic [LOG2N-1:0] bidx_ext_s;
    logic [LOG2N-1:0] h_s;
    logic [LOG2N-1:0] low_s;
    logic [LOG2N-1:0] addr_a_s;
    logic [LOG2N-2:0] tw_s;

    // Butterfly group base plus offset within the group; low_s < h_s always.
    always_comb begin
        bidx_ext_s = {1'b0, bidx_i};
        h_s        = LOG2N'(1) << stage_i;
        low_s      = bidx_ext_s & (h_s - LOG2N'(1));
        addr_a_s   = (((bidx_ext_s >> stage_i) << stage_i) << 1) | low_s;
        tw_s       = low_s[LOG2N-2:0] << (LAST_STAGE - stage_i);
        addr_a_o   = addr_a_s;
        addr_b_o   = addr_a_s + h_s;
        tw_o       = tw_s;
        if (tw_s == '0) begin
            mult_o = MULT_W_ONE;
        end else if (tw_s == TW_NEG_J) begin
            mult_o = MULT_W_NEG_J;
        end else begin
            mult_o = MULT_GENERAL;
        end
    end

endmodule

// File: rtl/fixed_point_iterative_fft_sequencer.sv
// Issues every butterfly of an in-place radix-2 DIT FFT to a shared butterfly
// unit, limiting commands in flight and draining each stage before the next.
module fixed_point_iterative_fft_sequencer
    import fixed_point_iterative_fft_pkg::*;
#(
    parameter int N = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int LOG2N = $clog2(N),
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1,
    localparam int BW = LOG2N - 1,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_val,
    output logic             start_rdy,
    output logic             cmd_val,
    input  logic             cmd_rdy,
    output logic [LOG2N-1:0] cmd_addr_a,
    output logic [LOG2N-1:0] cmd_addr_b,
    output logic [LOG2N-2:0] cmd_tw,
    output logic [SW-1:0]    cmd_stage,
    output logic [2:0]       cmd_mult,
    input  logic             wb_val,
    output logic             done_val,
    input  logic             done_rdy,
    output logic             busy,
    output logic             err
);

    localparam logic [BW-1:0] BIDX_LAST  = BW'(N / 2 - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);

    fft_state_e    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          err_q, err_d;
    logic          fire_s;

    assign start_rdy = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done_val  = (state_q == ST_DONE);
    assign cmd_val   = (state_q == ST_ISSUE) && (outst_q < OUT_MAX);
    assign cmd_stage = stage_q;
    assign err       = err_q;
    assign fire_s    = cmd_val && cmd_rdy;

    fixed_point_iterative_fft_agu #(.N(N)) u_agu (
        .stage_i  (stage_q),
        .bidx_i   (bidx_q),
        .addr_a_o (cmd_addr_a),
        .addr_b_o (cmd_addr_b),
        .tw_o     (cmd_tw),
        .mult_o   (cmd_mult)
    );

    // Next-state for the sequencer FSM, position counters, in-flight count and error flag.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bidx_d  = bidx_q;
        outst_d = outst_q;
        err_d   = err_q | (wb_val && (outst_q == '0));

        case (state_q)
            ST_IDLE: begin
                if (start_val) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    bidx_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fire_s) begin
                    bidx_d = bidx_q + BW'(1);
                    if (bidx_q == BIDX_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    bidx_d = bidx_q;
                end
            end
            // Stage boundary waits on the registered count so no read sees a stale sample.
            ST_DRAIN: begin
                if (outst_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + SW'(1);
                        bidx_d  = '0;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (done_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({fire_s, wb_val})
            2'b10: outst_d = outst_q + OW'(1);
            2'b01: begin
                if (outst_q != '0) begin
                    outst_d = outst_q - OW'(1);
                end else begin
                    outst_d = '0;
                end
            end
            default: outst_d = outst_q;
        endcase
    end

    // State registers; asynchronous reset forgets everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            bidx_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bidx_q  <= bidx_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fixed_point_iterative_fft_sequencer.sv
// Directed bench for the FFT sequencer (N=8, two butterflies in flight) with a
// scoreboard of expected commands popped on every observed command fire.
module tb_fixed_point_iterative_fft_sequencer;

    typedef struct {
        int a;
        int b;
        int tw;
        int m;
        int st;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_val;
    logic       start_rdy;
    logic       cmd_val;
    logic       cmd_rdy;
    logic [2:0] cmd_addr_a;
    logic [2:0] cmd_addr_b;
    logic [1:0] cmd_tw;
    logic [1:0] cmd_stage;
    logic [2:0] cmd_mult;
    logic       wb_val;
    logic       done_val;
    logic       done_rdy;
    logic       busy;
    logic       err;

    int checks = 0;
    int failures = 0;
    int fires = 0;
    int pend = 0;
    bit auto_wb = 1'b0;

    int s_cmd_val, s_done_val, s_busy, s_start_rdy, s_err;
    int s_a, s_b, s_tw, s_m;

    cmd_t sbq[$];

    int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_m  [12] = '{1, 1, 1, 1, 1, 4, 1, 4, 1, 0, 4, 0};

    fixed_point_iterative_fft_sequencer #(.N(8), .MAX_OUTSTANDING(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_val  (start_val),
        .start_rdy  (start_rdy),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_tw     (cmd_tw),
        .cmd_stage  (cmd_stage),
        .cmd_mult   (cmd_mult),
        .wb_val     (wb_val),
        .done_val   (done_val),
        .done_rdy   (done_rdy),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_xform();
        cmd_t c;
        for (int i = 0; i < 12; i++) begin
            c.a  = exp_a[i];
            c.b  = exp_b[i];
            c.tw = exp_tw[i];
            c.m  = exp_m[i];
            c.st = i / 4;
            sbq.push_back(c);
        end
    endtask

    // One clock cycle: sample on the falling edge, score any fire, then drive write-backs.
    task automatic cyc();
        bit   f;
        cmd_t e;
        @(negedge clk);
        s_cmd_val   = int'(cmd_val);
        s_done_val  = int'(done_val);
        s_busy      = int'(busy);
        s_start_rdy = int'(start_rdy);
        s_err       = int'(err);
        s_a         = int'(cmd_addr_a);
        s_b         = int'(cmd_addr_b);
        s_tw        = int'(cmd_tw);
        s_m         = int'(cmd_mult);
        f = (cmd_val === 1'b1) && (cmd_rdy === 1'b1);
        if (f) begin
            fires++;
            if (sbq.size() == 0) begin
                chk("unexpected_cmd", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("cmd_addr_a", s_a, e.a);
                chk("cmd_addr_b", s_b, e.b);
                chk("cmd_tw", s_tw, e.tw);
                chk("cmd_mult", s_m, e.m);
                chk("cmd_stage", int'(cmd_stage), e.st);
            end
        end
        pend = pend + (f ? 1 : 0) - ((wb_val === 1'b1) ? 1 : 0);
        if (pend < 0) pend = 0;
        @(posedge clk);
        #1;
        wb_val = auto_wb && (pend > 0);
    endtask

    initial begin
        reset     = 1'b0;
        start_val = 1'b0;
        cmd_rdy   = 1'b1;
        wb_val    = 1'b0;
        done_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_val", int'(cmd_val), 0);
        chk("rst_done_val", int'(done_val), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_start_rdy", int'(start_rdy), 1);
        reset = 1'b1;
        cyc();

        // Full transform, write-back one cycle after each fire, slow done ack.
        push_xform();
        fires = 0;
        auto_wb = 1'b1;
        start_val = 1'b1;
        cyc();
        chk("start_rdy_idle", s_start_rdy, 1);
        start_val = 1'b0;
        cyc();
        chk("cmd_val_after_start", s_cmd_val, 1);
        chk("busy_after_start", s_busy, 1);
        chk("start_rdy_busy", s_start_rdy, 0);
        for (int i = 0; i < 200 && s_done_val == 0; i++) cyc();
        chk("done_reached", s_done_val, 1);
        chk("total_fires", fires, 12);
        chk("sb_empty", sbq.size(), 0);
        repeat (3) begin
            cyc();
            chk("done_held", s_done_val, 1);
        end
        done_rdy = 1'b1;
        cyc();
        done_rdy = 1'b0;
        cyc();
        chk("done_dropped", s_done_val, 0);
        chk("start_rdy_back", s_start_rdy, 1);
        chk("busy_cleared", s_busy, 0);

        // Outstanding limit with write-backs withheld; replay from stage 0.
        push_xform();
        fires = 0;
        auto_wb = 1'b0;
        start_val = 1'b1;
        cyc();
        start_val = 1'b0;
        repeat (5) cyc();
        chk("fires_at_limit", fires, 2);
        chk("cmd_val_blocked", s_cmd_val, 0);
        wb_val = 1'b1;
        cyc();
        cyc();
        chk("one_more_fire", fires, 3);
        cyc();
        chk("blocked_again", s_cmd_val, 0);

        // Delayed final stage-0 write-backs gate the next stage.
        wb_val = 1'b1;
        cyc();
        cyc();
        chk("stage0_all_fired", fires, 4);
        repeat (10) begin
            cyc();
            chk("no_issue_in_drain", s_cmd_val, 0);
        end
        wb_val = 1'b1;
        cyc();
        cyc();
        wb_val = 1'b1;
        cyc();
        cyc();
        chk("drain_wb_plus1", s_cmd_val, 0);
        cyc();
        chk("drain_wb_plus2", s_cmd_val, 1);
        chk("stage1_first_fire", fires, 5);

        // Back-pressure holds the command fields stable.
        cmd_rdy = 1'b0;
        repeat (5) begin
            cyc();
            chk("hold_val", s_cmd_val, 1);
            chk("hold_addr_a", s_a, sbq[0].a);
            chk("hold_addr_b", s_b, sbq[0].b);
            chk("hold_tw", s_tw, sbq[0].tw);
            chk("hold_mult", s_m, sbq[0].m);
        end
        chk("no_fire_held", fires, 5);
        cmd_rdy = 1'b1;
        wb_val = 1'b1;
        cyc();
        chk("fire_with_wb", fires, 6);
        cyc();
        chk("count_kept_issue", s_cmd_val, 1);
        cyc();
        chk("count_kept_limit", s_cmd_val, 0);
        auto_wb = 1'b1;
        wb_val = 1'b1;
        for (int i = 0; i < 200 && s_done_val == 0; i++) cyc();
        chk("done2_reached", s_done_val, 1);
        chk("total_fires2", fires, 12);
        done_rdy = 1'b1;
        cyc();
        done_rdy = 1'b0;
        cyc();
        chk("start_rdy_back2", s_start_rdy, 1);
        chk("err_clean", s_err, 0);

        // Third run aborted by reset in stage 1.
        push_xform();
        fires = 0;
        start_val = 1'b1;
        cyc();
        start_val = 1'b0;
        for (int i = 0; i < 100 && fires < 5; i++) cyc();
        chk("reached_stage1", fires, 5);
        auto_wb = 1'b0;
        wb_val = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_cmd_val", int'(cmd_val), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_start_rdy", int'(start_rdy), 1);
        chk("abort_done_val", int'(done_val), 0);
        sbq.delete();
        pend = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Stray write-back while idle sets the sticky error.
        cyc();
        chk("err_before", s_err, 0);
        wb_val = 1'b1;
        cyc();
        cyc();
        chk("err_set", s_err, 1);
        repeat (3) cyc();
        chk("err_sticky", s_err, 1);
        reset = 1'b0;
        #1;
        chk("err_reset", int'(err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
